// File: rtl/gs232c_raminit_pkg.sv
// Shared encodings for the RAM initialisation controller: FSM states and
// init-pattern selectors.
package gs232c_raminit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int INIT_MODE_CONST = 0;
    localparam int INIT_MODE_INDEX = 1;

endpackage

// File: rtl/gs232c_raminit_ctrl.sv
// Sweeps every entry of BANKS equal-depth RAM banks writing an init pattern,
// once after reset and again on each start request; stalls on !ready.
//
// Handshake: a write is taken in every cycle where we != 0 and ready = 1;
// while ready = 0 the index, we and wdata hold unchanged.
module gs232c_raminit_ctrl
    import gs232c_raminit_pkg::*;
#(
    parameter int                 IDX_W     = 6,
    parameter int                 DEPTH     = 64,
    parameter int                 DATA_W    = 32,
    parameter int                 BANKS     = 1,
    parameter int                 INIT_MODE = INIT_MODE_CONST,
    parameter logic [DATA_W-1:0]  INIT_VAL  = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [BANKS-1:0]    bank_mask,
    input  logic                ready,
    output logic [IDX_W-1:0]    index,
    output logic [DATA_W-1:0]   wdata,
    output logic [BANKS-1:0]    we,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_o
);

    if (DEPTH < 2 || DEPTH > (1 << IDX_W) || BANKS < 1) begin : g_bad_params
        $error("gs232c_raminit_ctrl: DEPTH must be 2..2**IDX_W and BANKS >= 1");
    end

    // Terminal compare is against DEPTH-1 so non-power-of-two depths never
    // wander past the last real entry.
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    state_e              state_q;
    logic [IDX_W-1:0]    index_q;
    logic [IDX_W-1:0]    index_d;
    logic [BANKS-1:0]    we_q;
    logic                busy_q;
    logic                done_q;

    assign index_d = index_q + IDX_W'(1);

    // we_q doubles as the latched bank mask: it holds the mask for the whole
    // sweep and is cleared outside it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_SWEEP;
            index_q <= '0;
            we_q    <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_SWEEP: begin
                    if (ready) begin
                        if (index_q == LAST_IDX) begin
                            state_q <= ST_DONE;
                            index_q <= '0;
                            we_q    <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            index_q <= index_d;
                        end
                    end
                end

                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    we_q    <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (start) begin
                        if (bank_mask != '0) begin
                            state_q <= ST_SWEEP;
                            index_q <= '0;
                            we_q    <= bank_mask;
                            busy_q  <= 1'b1;
                        end else begin
                            // Empty mask: no writes, but the requester still
                            // gets its completion pulse.
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end
                    end
                end

                default: begin
                    state_q <= ST_IDLE;
                    index_q <= '0;
                    we_q    <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign index   = index_q;
    assign we      = we_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign state_o = state_q;
    assign wdata   = (INIT_MODE == INIT_MODE_INDEX) ? DATA_W'(index_q) : INIT_VAL;

endmodule

// File: tb/tb_gs232c_raminit_ctrl.sv
// Scoreboard bench for gs232c_raminit_ctrl: DEPTH=40 (non power of two),
// two banks, index pattern truncated to a 4-bit data word.
module tb_gs232c_raminit_ctrl;
  import gs232c_raminit_pkg::*;

  localparam int IDX_W  = 6;
  localparam int DEPTH  = 40;
  localparam int DATA_W = 4;
  localparam int BANKS  = 2;
  localparam int W      = 1 + BANKS + IDX_W + DATA_W;

  localparam logic [W-1:0] DONE_WORD = {1'b1, {(W-1){1'b0}}};

  logic              clock = 1'b0;
  logic              reset;
  logic              start;
  logic [BANKS-1:0]  bank_mask;
  logic              ready;
  logic [IDX_W-1:0]  index;
  logic [DATA_W-1:0] wdata;
  logic [BANKS-1:0]  we;
  logic              busy;
  logic              done;
  logic [1:0]        state_o;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;
  int checks = 0;
  int errors = 0;

  gs232c_raminit_ctrl #(
    .IDX_W     (IDX_W),
    .DEPTH     (DEPTH),
    .DATA_W    (DATA_W),
    .BANKS     (BANKS),
    .INIT_MODE (INIT_MODE_INDEX),
    .INIT_VAL  (4'hA)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .bank_mask (bank_mask),
    .ready     (ready),
    .index     (index),
    .wdata     (wdata),
    .we        (we),
    .busy      (busy),
    .done      (done),
    .state_o   (state_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [W-1:0] wr_word(input logic [BANKS-1:0] m, input int i);
    logic [IDX_W-1:0]  ix;
    logic [DATA_W-1:0] d;
    ix = IDX_W'(i);
    d  = ix[3:0];
    return {1'b0, m, ix, d};
  endfunction

  task automatic push_writes(input logic [BANKS-1:0] m, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(wr_word(m, i));
  endtask

  task automatic push_sweep(input logic [BANKS-1:0] m);
    push_writes(m, DEPTH);
    exp_q.push_back(DONE_WORD);
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    if (reset === 1'b0 && (done === 1'b1 || (we != '0 && ready === 1'b1))) begin
      mon_act = {done, we, index, wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", mon_act);
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_act !== mon_exp) begin
          errors++;
          $display("FAIL sb_word actual=%0h required=%0h", mon_act, mon_exp);
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Runs from just after the posedge that starts sweep cycle 0 until the
  // negedge of the cycle showing done; reports that cycle number.
  task automatic run_sweep(input int stall_at, input int pulse_at,
                           input int exp_cycles, input string name);
    int               n;
    bit               seen;
    logic [IDX_W-1:0] held_idx;
    logic [BANKS-1:0] held_we;
    n    = 0;
    seen = 1'b0;
    held_idx = '0;
    held_we  = '0;
    ready = !(stall_at >= 0 && (n == stall_at || n == stall_at + 1));
    if (pulse_at >= 0) start = (n == pulse_at);
    while (n <= 200) begin
      @(negedge clock);
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (stall_at >= 0 && n == stall_at) begin
        held_idx = index;
        held_we  = we;
        check({name, "_stall_idx"}, int'(index), stall_at);
      end
      if (stall_at >= 0 && (n == stall_at + 1 || n == stall_at + 2)) begin
        check({name, "_hold_idx"}, int'(index), int'(held_idx));
        check({name, "_hold_we"}, int'(we), int'(held_we));
      end
      n++;
      @(posedge clock);
      #1;
      ready = !(stall_at >= 0 && (n == stall_at || n == stall_at + 1));
      if (pulse_at >= 0) start = (n == pulse_at);
    end
    if (!seen) check({name, "_timeout"}, 0, 1);
    check({name, "_cycles"}, n, exp_cycles);
    check({name, "_done_we"}, int'(we), 0);
    ready = 1'b1;
    if (pulse_at >= 0) start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    bank_mask = '0;
    ready     = 1'b1;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_index", int'(index), 0);
    check("rst_we", int'(we), 3);
    check("rst_busy", int'(busy), 1);
    check("rst_done", int'(done), 0);
    check("rst_state", int'(state_o), int'(ST_SWEEP));

    // Post-reset sweep with ready high: done in cycle DEPTH
    push_sweep(2'b11);
    @(posedge clock); #1;
    reset = 1'b0;
    run_sweep(-1, -1, DEPTH, "post_reset");
    @(negedge clock);
    check("idle_we", int'(we), 0);
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
    check("idle_state", int'(state_o), int'(ST_IDLE));

    // Two stall cycles at index 5, plus a start pulse mid-sweep that must be ignored
    @(posedge clock); #1;
    start = 1'b1; bank_mask = 2'b11;
    push_sweep(2'b11);
    @(posedge clock); #1;
    start = 1'b0; bank_mask = 2'b01;
    run_sweep(5, 12, DEPTH + 2, "stall");

    // Start with a single bank selected
    @(posedge clock); #1;
    start = 1'b1; bank_mask = 2'b10;
    push_sweep(2'b10);
    @(posedge clock); #1;
    start = 1'b0;
    run_sweep(-1, -1, DEPTH, "mask10");

    // Empty mask: done one cycle after start, no writes
    @(posedge clock); #1;
    start = 1'b1; bank_mask = 2'b00;
    exp_q.push_back(DONE_WORD);
    @(posedge clock); #1;
    start = 1'b0;
    run_sweep(-1, -1, 0, "zero_mask");

    // start held high through DONE: back-to-back sweeps
    @(posedge clock); #1;
    start = 1'b1; bank_mask = 2'b01;
    push_sweep(2'b01);
    push_sweep(2'b01);
    @(posedge clock); #1;
    run_sweep(-1, -1, DEPTH, "b2b_first");
    @(posedge clock); #1;
    start = 1'b0;
    run_sweep(-1, -1, DEPTH, "b2b_second");

    // Reset at index 20 restarts the full all-bank sweep, no done for the aborted one
    @(posedge clock); #1;
    start = 1'b1; bank_mask = 2'b01;
    push_writes(2'b01, 20);
    @(posedge clock); #1;
    start = 1'b0;
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("abort_pre_idx", int'(index), 20);
    @(posedge clock); #1;
    @(negedge clock);
    check("abort_index", int'(index), 0);
    check("abort_we", int'(we), 3);
    check("abort_done", int'(done), 0);
    check("abort_busy", int'(busy), 1);
    push_sweep(2'b11);
    @(posedge clock); #1;
    reset = 1'b0;
    run_sweep(-1, -1, DEPTH, "after_abort");

    // Drain
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("final_state", int'(state_o), int'(ST_IDLE));
    check("queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gs232c_raminit_ctrl.md
# gs232c_raminit_ctrl

Parametrised RAM initialisation controller for cache tag/valid arrays and predictor tables. Sweeps every entry of one or more equal-depth RAM banks and writes an init pattern: automatically after reset, and again on a `start` request (cache flush). Sits beside the array write port behind an arbiter that can stall it. Adds non-power-of-two depth, multi-bank masking, a ready handshake, a data pattern and a completion pulse.

## Interface
- `IDX_W`, 6: index width.
- `DEPTH`, 64: entries per bank; legal range 2..2^IDX_W.
- `DATA_W`, 32: write data width.
- `BANKS`, 1: number of banks swept in parallel.
- `INIT_MODE`, 0: 0 = constant `INIT_VAL`; 1 = entry index, zero-extended or truncated to `DATA_W`.
- `INIT_VAL`, 0: constant pattern used when `INIT_MODE`=0.

Ports:
- `clock`  in  1  clock.
- `reset`  in  1  reset, synchronous, active-high.
- `start`  in  1  re-init request; sampled only in IDLE or DONE.
- `bank_mask`  in  BANKS  banks to initialise; latched with `start`.
- `ready`  in  1  arbiter grant; the write is taken in any cycle where `we`≠0 and `ready`=1.
- `index`  out  IDX_W  current entry address.
- `wdata`  out  DATA_W  pattern for `index`.
- `we`  out  BANKS  per-bank write enable.
- `busy`  out  1  high in SWEEP.
- `done`  out  1  one-cycle pulse after the last write.

## Operation
- States: IDLE, SWEEP, DONE. All outputs are Moore outputs decoded from registers.
- Reset: state=SWEEP, `index`=0, latched mask=all ones, `busy`=1, `done`=0, `we`=all ones. The post-reset sweep covers every bank and needs no `start`.
- SWEEP: `we` = latched mask. If `ready`=1 and `index`≠DEPTH-1, `index` increments. If `ready`=1 and `index`=DEPTH-1, go to DONE and set `index`=0. If `ready`=0, all state holds and `we`/`index`/`wdata` stay stable.
- DONE: lasts exactly one cycle with `done`=1, `we`=0, `busy`=0. Next state is IDLE, unless `start` is sampled.
- IDLE: `we`=0, `busy`=0. On `start`=1:
  - If `bank_mask`≠0: latch the mask, set `index`=0, and enter SWEEP.
  - If `bank_mask`=0: go straight to DONE. There are no writes and `done` still pulses.
- `start` sampled in DONE behaves exactly as in IDLE. `start` in SWEEP is ignored and not queued.
- `index` never exceeds DEPTH-1. The terminal compare is against DEPTH-1, never all-ones, so non-power-of-two DEPTH works.
- `wdata`: INIT_MODE 0 gives `INIT_VAL[DATA_W-1:0]`. INIT_MODE 1 gives `index` zero-extended or truncated to DATA_W. It is valid whenever `we`≠0.
- `reset` mid-sweep aborts the current sweep and restarts the full post-reset sweep. No `done` is issued for the aborted sweep.

## Timing
- Latency from `start` in IDLE to the first `we`: 1 cycle.
- Sweep length with `ready` held high: exactly DEPTH cycles of `we`≠0. `done` follows in the next cycle.
- From reset deassertion with `ready` high: `done` appears in cycle DEPTH, counting the first post-reset cycle as 0.
- Each stall cycle (`ready`=0) adds one cycle. No write is lost or duplicated.
- `start` is a level, sampled per cycle. Holding it high through DONE→SWEEP→DONE gives back-to-back sweeps separated only by the one DONE cycle.

## Structure
- Shared package `gs232c_raminit_pkg` holds the state encoding constants (IDLE, SWEEP, DONE; 2 bits) and `INIT_MODE` value constants.
- Single module, with no sub-module: one state register, an index counter, a mask register, and output decode.
- Elaboration check: DEPTH in 2..2^IDX_W, and BANKS ≥1.

## Test plan
- Reset, `ready`=1, DEPTH=64, BANKS=2: `we`=2'b11 for indexes 0..63 in consecutive cycles, then `done`=1 for one cycle, then IDLE with `we`=0.
- DEPTH=40, IDX_W=6: last write at index 39, and index 40..63 never appear. `done` follows the index-39 write.
- `ready` toggled 1,0,0,1 in SWEEP: `index` and `we` hold through the two stall cycles, with no skipped or repeated index. The total sweep is DEPTH+2 cycles.
- IDLE, `start`=1 with `bank_mask`=2'b10: the next cycle shows `we`=2'b10 and `index`=0, then a full sweep. `start` pulsed mid-sweep has no effect.
- INIT_MODE=1, DATA_W=4, DEPTH=32: `wdata` = `index[3:0]` each write. With `bank_mask`=0 on `start`: `done` pulses 1 cycle later and `we` never asserts.
- `reset` asserted at index 20: the next cycle shows `index`=0, `we`=all ones, no `done`, and the full sweep completes normally.
